// File: rtl/fads_mux_pkg.sv
// FADS mux scheduler shared types and constants.
package fads_mux_pkg;

    localparam int MUX_NCH      = 6;
    localparam int MUX_AW       = 3;
    localparam int AVG_MAX_LOG2 = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SETTLE  = 3'd2,
        ACQUIRE = 3'd3,
        EMIT    = 3'd4
    } mux_state_t;

endpackage

// File: rtl/fads_mux_next_ch.sv
// Priority finder: lowest set mask bit strictly above ptr,
// or the lowest set bit overall when start is high.
module fads_mux_next_ch
    import fads_mux_pkg::*;
#(
    parameter int NCH = MUX_NCH,
    parameter int AW  = MUX_AW
) (
    input  logic [NCH-1:0] mask,
    input  logic [AW-1:0]  ptr,
    input  logic           start,
    output logic           next_valid,
    output logic [AW-1:0]  next_ptr
);

    always_comb begin
        next_valid = 1'b0;
        next_ptr   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k] && (start || k > int'(ptr))) begin
                next_valid = 1'b1;
                next_ptr   = AW'(k);
            end
        end
    end

endmodule

// File: rtl/fads_mux_scheduler.sv
// Steps the FADS analog mux through enabled channels, settling and
// averaging 2^n ADC samples per channel.
module fads_mux_scheduler
    import fads_mux_pkg::*;
#(
    parameter int DWT  = 14,
    parameter int NCH  = MUX_NCH,
    parameter int AW   = MUX_AW,
    parameter int CW   = 16,
    parameter int ACCW = DWT + AVG_MAX_LOG2
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rst_i,
    input  logic                  enable_i,
    input  logic [NCH-1:0]        active_channels_i,
    input  logic [CW-1:0]         settle_cycles_i,
    input  logic [2:0]            avg_log2_i,
    input  logic signed [DWT-1:0] adc_a_i,
    output logic [AW-1:0]         mux_addr_o,
    output logic                  signal_stable_o,
    output logic                  sample_valid_o,
    output logic [AW-1:0]         sample_ch_o,
    output logic signed [DWT-1:0] sample_data_o,
    output logic                  frame_done_o,
    output logic                  busy_o
);

    localparam int QW = AVG_MAX_LOG2 + 1;

    mux_state_t state_q, state_d;

    logic [NCH-1:0]         mask_q;
    logic [AW-1:0]          ptr_q;
    logic [AW-1:0]          mux_addr_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             n_q;
    logic [QW-1:0]          acq_cnt_q;
    logic signed [ACCW-1:0] acc_q;
    logic                   valid_q;
    logic [AW-1:0]          ch_q;
    logic signed [DWT-1:0]  data_q;
    logic                   fdone_q;

    logic [NCH-1:0]         f_mask;
    logic                   f_start;
    logic                   nxt_valid;
    logic [AW-1:0]          nxt_ptr;
    logic [QW-1:0]          acq_max;
    logic                   acq_last;
    logic signed [ACCW-1:0] acc_sum;

    // In IDLE the finder looks at the live mask to pick the first channel.
    assign f_start = (state_q == IDLE);
    assign f_mask  = f_start ? active_channels_i : mask_q;

    fads_mux_next_ch #(
        .NCH (NCH),
        .AW  (AW)
    ) u_next_ch (
        .mask       (f_mask),
        .ptr        (ptr_q),
        .start      (f_start),
        .next_valid (nxt_valid),
        .next_ptr   (nxt_ptr)
    );

    assign acq_max  = (QW'(1) << n_q) - QW'(1);
    assign acq_last = (acq_cnt_q == acq_max);
    assign acc_sum  = acc_q + {{(ACCW-DWT){adc_a_i[DWT-1]}}, adc_a_i};

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_i && |active_channels_i) state_d = SELECT;
            SELECT:  state_d = (settle_cycles_i != '0) ? SETTLE : ACQUIRE;
            SETTLE:  if (cnt_q == CW'(1)) state_d = ACQUIRE;
            ACQUIRE: if (acq_last) state_d = EMIT;
            EMIT:    state_d = nxt_valid ? SELECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sample outputs are loaded on the last ACQUIRE cycle so they are
    // visible, registered, during EMIT and hold until the next EMIT.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            mask_q     <= '0;
            ptr_q      <= '0;
            mux_addr_q <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
            acq_cnt_q  <= '0;
            acc_q      <= '0;
            valid_q    <= 1'b0;
            ch_q       <= '0;
            data_q     <= '0;
            fdone_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            fdone_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (state_d == SELECT) begin
                        mask_q <= active_channels_i;
                        ptr_q  <= nxt_ptr;
                    end
                end
                SELECT: begin
                    mux_addr_q <= ptr_q;
                    cnt_q      <= settle_cycles_i;
                    n_q        <= avg_log2_i;
                    acc_q      <= '0;
                    acq_cnt_q  <= '0;
                end
                SETTLE: cnt_q <= cnt_q - CW'(1);
                ACQUIRE: begin
                    acc_q     <= acc_sum;
                    acq_cnt_q <= acq_cnt_q + QW'(1);
                    if (acq_last) begin
                        valid_q <= 1'b1;
                        ch_q    <= ptr_q;
                        data_q  <= DWT'(acc_sum >>> n_q);
                        fdone_q <= !nxt_valid;
                    end
                end
                EMIT: if (nxt_valid) ptr_q <= nxt_ptr;
                default: ;
            endcase
        end
    end

    assign mux_addr_o      = mux_addr_q;
    assign signal_stable_o = (state_q == ACQUIRE);
    assign sample_valid_o  = valid_q;
    assign sample_ch_o     = ch_q;
    assign sample_data_o   = data_q;
    assign frame_done_o    = fdone_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_fads_mux_scheduler.sv
// Scoreboard bench for fads_mux_scheduler: directed frames, expected
// samples queued by stimulus and checked by an output monitor.
module tb_fads_mux_scheduler;

    logic               clk = 1'b0;
    logic               adc_rst;
    logic               enable;
    logic [5:0]         mask;
    logic [15:0]        settle;
    logic [2:0]         avg_log2;
    logic signed [13:0] adc;
    logic [2:0]         mux_addr;
    logic               stable;
    logic               s_valid;
    logic [2:0]         s_ch;
    logic signed [13:0] s_data;
    logic               f_done;
    logic               busy;

    typedef struct {
        int ch;
        int data;
        int fd;
        int gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   stable_cnt = 0;
    int   mode = 0;
    int   tab[8];
    bit   alt = 1'b0;

    always #5 clk = ~clk;

    fads_mux_scheduler dut (
        .adc_clk_i         (clk),
        .adc_rst_i         (adc_rst),
        .enable_i          (enable),
        .active_channels_i (mask),
        .settle_cycles_i   (settle),
        .avg_log2_i        (avg_log2),
        .adc_a_i           (adc),
        .mux_addr_o        (mux_addr),
        .signal_stable_o   (stable),
        .sample_valid_o    (s_valid),
        .sample_ch_o       (s_ch),
        .sample_data_o     (s_data),
        .frame_done_o      (f_done),
        .busy_o            (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input int data, input int fd,
                        input int gap);
        exp_t e;
        e.ch = ch; e.data = data; e.fd = fd; e.gap = gap;
        q.push_back(e);
    endtask

    always @(posedge clk) cyc++;

    // ADC model: per-address table, alternating -3/-2, or constant.
    always @(negedge clk) begin
        if (stable) alt = ~alt;
        else        alt = 1'b0;
        case (mode)
            0:       adc = 14'(tab[mux_addr]);
            1:       adc = alt ? -14'sd3 : -14'sd2;
            default: adc = -14'sd8192;
        endcase
        if (stable) stable_cnt++;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!adc_rst && f_done && !s_valid)
            chk("frame_done_without_valid", 0, 1);
        if (!adc_rst && s_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_sample_ch", int'(s_ch), -1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sample_ch", int'(s_ch), e.ch);
                chk("sample_data", int'(s_data), e.data);
                chk("frame_done", int'(f_done), e.fd);
                if (e.gap != 0) chk("sample_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
    end

    task automatic wait_frame(input int max);
        int seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (f_done) begin
                seen = 1;
                break;
            end
        end
        chk("frame_done_timeout", seen, 1);
    endtask

    task automatic wait_acq(input int ch, input int max);
        int seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (stable && int'(mux_addr) == ch) begin
                seen = 1;
                break;
            end
        end
        chk("acquire_wait_timeout", seen, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_mux_addr"}, int'(mux_addr), 0);
        chk({tag, "_stable"}, int'(stable), 0);
        chk({tag, "_valid"}, int'(s_valid), 0);
        chk({tag, "_ch"}, int'(s_ch), 0);
        chk({tag, "_data"}, int'(s_data), 0);
        chk({tag, "_frame_done"}, int'(f_done), 0);
    endtask

    initial begin
        int base;
        tab = '{-100, -50, 0, 50, 10, 20, 0, 0};
        adc_rst  = 1'b1;
        enable   = 1'b0;
        mask     = 6'b0;
        settle   = 16'd0;
        avg_log2 = 3'd0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        adc_rst = 1'b0;

        // Empty mask with enable never leaves IDLE
        enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("empty_mask_busy", int'(busy), 0);
        enable = 1'b0;
        @(negedge clk);

        // Test 1: three-channel frame; enable drops mid-frame
        mode = 0; mask = 6'b101001; settle = 16'd4; avg_log2 = 3'd2;
        push(0, -100, 0, 0);
        push(3, 50, 0, 10);
        push(5, 20, 1, 10);
        base = stable_cnt;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t1_busy_started", int'(busy), 1);
        enable = 1'b0;
        wait_frame(60);
        chk("t1_stable_cycles", stable_cnt - base, 12);
        @(negedge clk);
        chk("t1_busy_after", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("t1_stays_idle", int'(busy), 0);

        // Test 2a: floor rounding of a negative average
        mode = 1; mask = 6'b000001; settle = 16'd2; avg_log2 = 3'd2;
        push(0, -3, 1, 0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_frame(30);
        @(negedge clk);

        // Test 2b: 128 full-scale negative samples
        mode = 2; avg_log2 = 3'd7;
        push(0, -8192, 1, 0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_frame(200);
        @(negedge clk);

        // Test 3: minimal timing, back-to-back frames
        mode = 0; mask = 6'b000001; settle = 16'd0; avg_log2 = 3'd0;
        push(0, -100, 1, 0);
        push(0, -100, 1, 4);
        push(0, -100, 1, 4);
        enable = 1'b1;
        wait_frame(20);
        wait_frame(20);
        wait_frame(20);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("t3_idle", int'(busy), 0);

        // Test 4: mask change mid-frame applies to the next frame
        mask = 6'b001111; settle = 16'd1; avg_log2 = 3'd1;
        push(0, -100, 0, 0);
        push(1, -50, 0, 5);
        push(2, 0, 0, 5);
        push(3, 50, 1, 5);
        push(4, 10, 0, 6);
        push(5, 20, 1, 5);
        enable = 1'b1;
        wait_acq(1, 40);
        mask = 6'b110000;
        wait_frame(40);
        wait_frame(40);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_idle", int'(busy), 0);

        // Test 5: reset during ch3 acquisition drops that sample
        mask = 6'b101001; settle = 16'd4; avg_log2 = 3'd2;
        push(0, -100, 0, 0);
        enable = 1'b1;
        wait_acq(3, 60);
        adc_rst = 1'b1;
        enable  = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        adc_rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("after_reset_idle", int'(busy), 0);
        chk("scoreboard_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fads_mux_scheduler.md
Name: fads_mux_scheduler

Overview:
Sequences the FADS analog multiplexer through the enabled detector channels and paces channel switching. For each channel it waits a programmable settle time, then averages 2^n ADC samples. Each averaged sample is emitted tagged with its channel number, and a frame-done strobe is raised when the scan completes. It sits between the FADS register bank (mask and timing inputs) and the external mux address pins and sort logic, and supplies mux_addr and signal_stable to downstream consumers.

Parameters:
DWT, 14, ADC sample width (signed two's complement)
NCH, 6, number of mux channels; NCH <= 2**AW required
AW, 3, mux address width
CW, 16, settle counter width
ACCW, DWT+7, accumulator width (holds 2^7 full-scale samples without overflow)

Ports:
adc_clk_i  in  1  ADC clock; all logic on rising edge
adc_rst_i  in  1  synchronous active-high reset
enable_i  in  1  run continuous scan frames while high
active_channels_i  in  NCH  channel enable mask; bit k enables mux address k
settle_cycles_i  in  CW  cycles to wait after each address change
avg_log2_i  in  3  samples averaged per channel = 2**avg_log2_i (1..128)
adc_a_i  in  DWT  signed ADC sample
mux_addr_o  out  AW  registered mux address
signal_stable_o  out  1  high while the current channel is being sampled
sample_valid_o  out  1  one-cycle strobe: averaged sample ready
sample_ch_o  out  AW  channel number of the current sample
sample_data_o  out  DWT  signed averaged sample
frame_done_o  out  1  one-cycle strobe coinciding with the last sample_valid_o of a frame
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: synchronous, active-high, takes effect at the next edge from any state. State goes to IDLE. All outputs go to 0, including mux_addr_o. Accumulator and counters are cleared.
- States: IDLE, SELECT, SETTLE, ACQUIRE, EMIT.
- IDLE:
  - If enable_i=1 and active_channels_i != 0: snapshot the mask into mask_q, set ptr to the lowest set bit, and go to SELECT.
  - Otherwise stay in IDLE; mux_addr_o holds its last value.
- SELECT (1 cycle):
  - mux_addr_o <= ptr.
  - Settle counter <= settle_cycles_i; timing inputs are sampled here.
  - Go to SETTLE if settle_cycles_i != 0, else go straight to ACQUIRE.
- SETTLE:
  - Lasts exactly settle_cycles_i cycles, with the counter decrementing.
  - When the counter reaches 1, go to ACQUIRE.
- ACQUIRE:
  - Lasts exactly 2**n cycles, where n is avg_log2_i as latched in SELECT.
  - Each cycle, acc += sign-extended adc_a_i; acc starts from 0.
  - signal_stable_o is high exactly during the ACQUIRE cycles (registered, state-aligned).
- EMIT (1 cycle):
  - sample_valid_o=1, sample_ch_o=ptr, sample_data_o = acc >>> n (arithmetic shift, i.e. floor).
  - If a set bit above ptr exists in mask_q: ptr <= that bit, go to SELECT.
  - Otherwise: frame_done_o=1 and go to IDLE. A new frame can start on the following cycle, so there is one IDLE cycle between frames.
- Per-channel period: 2 + settle + 2**n cycles.
- sample_ch_o and sample_data_o hold their values until the next EMIT.
- Mask changes mid-frame are ignored; the new mask applies at the next frame start.
- enable_i falling mid-frame: the current frame completes normally, then the block stays in IDLE.
- A mask with bits at or above NCH cannot occur (the mask is NCH bits wide).
- Mask = 0 with enable_i=1: the block stays in IDLE with busy_o=0.
- Reset during ACQUIRE: the partial accumulation is discarded and no sample_valid_o is emitted.

Decomposition:
- Package fads_mux_pkg holds:
  - the state enum (3-bit encoding);
  - the constants MUX_NCH=6, MUX_AW=3, AVG_MAX_LOG2=7.
- Sub-module fads_mux_next_ch: combinational priority finder. Inputs are mask_q and ptr; outputs are next_valid and next_ptr (lowest set bit strictly above ptr). The same finder, driven with a start flag, produces the first set bit.

Test Plan:
1. Mask 6'b101001, settle 4, avg_log2 2; bench drives adc = -100/-50/0/50/10/… per mux_addr.
   -> samples (ch0,-100), (ch3,50), (ch5,VAL5), spaced 10 cycles apart.
   -> frame_done_o coincides with ch5.
   -> signal_stable_o is high 4 cycles per channel.
2. avg_log2 2; adc alternates -3,-2,-3,-2 -> sample_data_o = -3 (sum -10 >>> 2, floor).
   avg_log2 7 with adc constant -8192 -> -8192, no overflow.
3. Settle 0, avg_log2 0, mask 6'b000001 -> SELECT, ACQUIRE, EMIT, IDLE, SELECT…
   Sample period 3 cycles plus 1 IDLE cycle per frame.
4. Mask changed from 6'b001111 to 6'b110000 during the ch1 ACQUIRE -> ch2 and ch3 are still emitted in that frame; the next frame scans ch4 and ch5.
5. adc_rst_i pulsed for 1 cycle during ACQUIRE of ch3 -> next cycle all outputs are 0, state is IDLE, and no sample_valid_o for ch3.
   enable_i dropped mid-frame -> the frame finishes with frame_done_o, then busy_o=0.
